sprite_pixel_pipe: RTL and testbench

//  Pixel-colour stage directly downstream of the 640x480p60 timing generator. Consumes sx/sy/de/hsync/vsync,

---
 rtl/invaders_pkg.sv | 50 +++++
 rtl/sprite_rom.sv | 23 ++
 rtl/sprite_pixel_pipe.sv | 131 +++++++++++++
 tb/tb_sprite_pixel_pipe.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/invaders_pkg.sv
// Shared constants, types and sprite bitmaps for the invader pixel pipeline.
package invaders_pkg;

  localparam int unsigned H_ACTIVE    = 640;
  localparam int unsigned V_ACTIVE    = 480;
  localparam int unsigned SPR_W       = 16;
  localparam int unsigned SPR_H       = 8;
  localparam int unsigned SCALE_LOG2  = 1;
  localparam int unsigned ANIM_FRAMES = 30;
  localparam int unsigned SPR_X0      = 304;
  localparam int unsigned SPR_Y0      = 232;
  localparam int unsigned LATENCY     = 3;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned BOX_W   = 11;
  localparam int unsigned COL_W   = 4;
  localparam int unsigned ROW_W   = 3;
  localparam int unsigned ROM_AW  = 1 + ROW_W + COL_W;
  localparam int unsigned CNT_W   = 5;

  typedef logic [11:0] rgb444_t;

  localparam rgb444_t SPR_COLOR = 12'h0F0;
  localparam rgb444_t BG_COLOR  = 12'h000;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, de: 1'b0};

  // Row r is element [r]; bit c of a row is sprite column c (column 0 is bit 0).
  typedef logic [SPR_H-1:0][SPR_W-1:0] bitmap_t;

  localparam bitmap_t SPR_PH0 = {16'hC003, 16'h1BD8, 16'h0C30, 16'hFFFF,
                                 16'h399C, 16'h3FFC, 16'h1FF8, 16'h07E0};
  localparam bitmap_t SPR_PH1 = {16'h6006, 16'h300C, 16'h0C30, 16'hFFFF,
                                 16'h399C, 16'h3FFC, 16'h1FF8, 16'h07E0};

  function automatic logic sprite_bit(input logic phase,
                                      input logic [ROW_W-1:0] row,
                                      input logic [COL_W-1:0] col);
    bitmap_t bm;
    bm = phase ? SPR_PH1 : SPR_PH0;
    return bm[row][col];
  endfunction

endpackage

// File: rtl/sprite_rom.sv
// Synchronous-read sprite bitmap ROM, address {phase,row,col}, one-cycle latency.
module sprite_rom
  import invaders_pkg::*;
(
  input  logic              clk_pix,
  input  logic              rst_pix_n,
  input  logic [ROM_AW-1:0] i_addr,
  output logic              o_bit
);

  logic r_bit;

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      r_bit <= 1'b0;
    end else begin
      r_bit <= sprite_bit(i_addr[ROM_AW-1], i_addr[COL_W +: ROW_W], i_addr[COL_W-1:0]);
    end
  end

  assign o_bit = r_bit;

endmodule

// File: rtl/sprite_pixel_pipe.sv
// Colour stage behind the 640x480 timing generator: draws one scaled, animated
// invader over the background, with tear-free position updates at the frame boundary.
module sprite_pixel_pipe
  import invaders_pkg::*;
(
  input  logic        clk_pix,
  input  logic        rst_pix_n,
  input  logic [9:0]  sx,
  input  logic [9:0]  sy,
  input  logic        de,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        pos_valid,
  output logic        pos_ready,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
  output logic [11:0] rgb,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        de_o,
  output logic        frame_start
);

  localparam int unsigned BOX_X = SPR_W << SCALE_LOG2;
  localparam int unsigned BOX_Y = SPR_H << SCALE_LOG2;

  logic [COORD_W-1:0] r_act_x, r_act_y, r_shd_x, r_shd_y;
  logic               r_pending, r_pos_ready, r_phase, r_frame_start;
  logic [CNT_W-1:0]   r_frame_cnt;

  logic               w_commit, w_xfer, w_pend_nxt;
  logic [BOX_W-1:0]   w_sx, w_sy, w_px, w_py;
  logic               w_in_x, w_in_y;
  logic [COL_W-1:0]   w_col;
  logic [ROW_W-1:0]   w_row;

  sync_t              r_sync [LATENCY];
  logic               r_s1_in_box, r_s2_in_box;
  logic [ROM_AW-1:0]  r_s1_addr;
  logic               w_spr_bit;
  rgb444_t            r_rgb;

  // Box test in 11 bits so a sprite near the right/bottom edge never wraps.
  always_comb begin
    w_commit   = (sx == '0) && (sy == COORD_W'(V_ACTIVE));
    w_xfer     = pos_valid && r_pos_ready;
    w_pend_nxt = w_xfer | (r_pending & ~w_commit);
    w_sx       = {1'b0, sx};
    w_sy       = {1'b0, sy};
    w_px       = {1'b0, r_act_x};
    w_py       = {1'b0, r_act_y};
    w_in_x     = (w_sx >= w_px) && (w_sx < (w_px + BOX_W'(BOX_X)));
    w_in_y     = (w_sy >= w_py) && (w_sy < (w_py + BOX_W'(BOX_Y)));
    w_col      = COL_W'((w_sx - w_px) >> SCALE_LOG2);
    w_row      = ROW_W'((w_sy - w_py) >> SCALE_LOG2);
  end

  // Position handshake, frame-boundary commit and animation phase.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      r_act_x       <= COORD_W'(SPR_X0);
      r_act_y       <= COORD_W'(SPR_Y0);
      r_shd_x       <= '0;
      r_shd_y       <= '0;
      r_pending     <= 1'b0;
      r_pos_ready   <= 1'b1;
      r_phase       <= 1'b0;
      r_frame_cnt   <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_commit;
      r_pending     <= w_pend_nxt;
      r_pos_ready   <= ~w_pend_nxt;
      if (w_commit) begin
        if (r_pending) begin
          r_act_x <= r_shd_x;
          r_act_y <= r_shd_y;
        end
        if (r_frame_cnt == CNT_W'(ANIM_FRAMES - 1)) begin
          r_frame_cnt <= '0;
          r_phase     <= ~r_phase;
        end else begin
          r_frame_cnt <= r_frame_cnt + CNT_W'(1);
        end
      end
      if (w_xfer) begin
        r_shd_x <= pos_x;
        r_shd_y <= pos_y;
      end
    end
  end

  // Three-stage pixel pipeline: box/coords, ROM lookup, colour mux.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      for (int i = 0; i < LATENCY; i++) r_sync[i] <= SYNC_IDLE;
      r_s1_in_box <= 1'b0;
      r_s2_in_box <= 1'b0;
      r_s1_addr   <= '0;
      r_rgb       <= '0;
    end else begin
      r_sync[0] <= '{hsync: hsync, vsync: vsync, de: de};
      for (int i = 1; i < LATENCY; i++) r_sync[i] <= r_sync[i-1];
      r_s1_in_box <= w_in_x && w_in_y;
      r_s1_addr   <= {r_phase, w_row, w_col};
      r_s2_in_box <= r_s1_in_box;
      if (!r_sync[LATENCY-2].de) begin
        r_rgb <= '0;
      end else if (r_s2_in_box && w_spr_bit) begin
        r_rgb <= SPR_COLOR;
      end else begin
        r_rgb <= BG_COLOR;
      end
    end
  end

  sprite_rom u_rom (
    .clk_pix   (clk_pix),
    .rst_pix_n (rst_pix_n),
    .i_addr    (r_s1_addr),
    .o_bit     (w_spr_bit)
  );

  assign pos_ready   = r_pos_ready;
  assign frame_start = r_frame_start;
  assign rgb         = r_rgb;
  assign hsync_o     = r_sync[LATENCY-1].hsync;
  assign vsync_o     = r_sync[LATENCY-1].vsync;
  assign de_o        = r_sync[LATENCY-1].de;

endmodule

// File: tb/tb_sprite_pixel_pipe.sv
// Scoreboard bench for sprite_pixel_pipe: per-cycle expected outputs queued at drive time.
module tb_sprite_pixel_pipe;
  import invaders_pkg::*;

  logic       clk_pix = 1'b0;
  logic       rst_pix_n = 1'b1;
  logic [9:0] sx = '0, sy = '0, pos_x = '0, pos_y = '0;
  logic       de = 1'b0, hsync = 1'b1, vsync = 1'b1, pos_valid = 1'b0;
  logic       pos_ready, hsync_o, vsync_o, de_o, frame_start;
  logic [11:0] rgb;

  always #5 clk_pix = ~clk_pix;

  sprite_pixel_pipe dut (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .sx(sx), .sy(sy), .de(de),
    .hsync(hsync), .vsync(vsync), .pos_valid(pos_valid), .pos_ready(pos_ready),
    .pos_x(pos_x), .pos_y(pos_y), .rgb(rgb), .hsync_o(hsync_o), .vsync_o(vsync_o),
    .de_o(de_o), .frame_start(frame_start)
  );

  localparam logic [11:0] GRN = 12'h0F0;
  localparam logic [11:0] BLK = 12'h000;

  typedef struct { logic [11:0] rgb; logic hs; logic vs; logic de; } exp_t;
  typedef struct { int x; int y; logic [11:0] exp_rgb; } vec_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] bm [2][8];

  // Reference model state
  int m_ax, m_ay, m_shx, m_shy, m_cnt;
  bit m_pend, m_phase, m_fs;

  function automatic logic [11:0] model_rgb(int x, int y, bit d);
    int c, r;
    if (!d) return BLK;
    if (x >= m_ax && x < m_ax + 32 && y >= m_ay && y < m_ay + 16) begin
      c = (x - m_ax) / 2;
      r = (y - m_ay) / 2;
      return bm[m_phase][r][c] ? GRN : BLK;
    end
    return BLK;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ax = 304; m_ay = 232; m_shx = 0; m_shy = 0; m_cnt = 0;
    m_pend = 0; m_phase = 0; m_fs = 0;
  endtask

  task automatic step(input int x, input int y, input bit d, input bit hs, input bit vs,
                      input bit pv, input int px, input int py,
                      input bit fx, input logic [11:0] frgb);
    exp_t e;
    bit   commit, xfer;
    @(negedge clk_pix);
    check("pos_ready", 32'(pos_ready), 32'(!m_pend));
    check("frame_start", 32'(frame_start), 32'(m_fs));
    if (sbq.size() >= 3) begin
      e = sbq.pop_front();
      check("rgb", 32'(rgb), 32'(e.rgb));
      check("hsync_o", 32'(hsync_o), 32'(e.hs));
      check("vsync_o", 32'(vsync_o), 32'(e.vs));
      check("de_o", 32'(de_o), 32'(e.de));
    end
    sx = 10'(x); sy = 10'(y); de = d; hsync = hs; vsync = vs;
    pos_valid = pv; pos_x = 10'(px); pos_y = 10'(py);
    e.rgb = fx ? frgb : model_rgb(x, y, d);
    e.hs = hs; e.vs = vs; e.de = d;
    sbq.push_back(e);
    commit = (x == 0 && y == 480);
    xfer   = pv && !m_pend;
    m_fs   = commit;
    if (commit) begin
      if (m_pend) begin m_ax = m_shx; m_ay = m_shy; m_pend = 0; end
      if (m_cnt == 29) begin m_cnt = 0; m_phase = !m_phase; end
      else m_cnt++;
    end
    if (xfer) begin m_shx = px; m_shy = py; m_pend = 1; end
  endtask

  task automatic pix(input int x, input int y);
    step(x, y, (x < H_ACTIVE && y < 480), 1, 1, 0, 0, 0, 0, BLK);
  endtask

  task automatic pixf(input int x, input int y, input logic [11:0] exp_rgb);
    step(x, y, (x < H_ACTIVE && y < 480), 1, 1, 0, 0, 0, 1, exp_rgb);
  endtask

  task automatic commit_frame(input bit pv, input int px, input int py);
    step(0, 480, 0, 1, 1, pv, px, py, 0, BLK);
  endtask

  task automatic idle();
    step(700, 10, 0, 1, 1, 0, 0, 0, 0, BLK);
  endtask

  task automatic do_reset();
    exp_t e;
    @(negedge clk_pix);
    rst_pix_n = 1'b0;
    sx = '0; sy = '0; de = 1'b0; hsync = 1'b1; vsync = 1'b1;
    pos_valid = 1'b0; pos_x = '0; pos_y = '0;
    repeat (2) @(negedge clk_pix);
    rst_pix_n = 1'b1;
    model_reset();
    sbq.delete();
    e.rgb = BLK; e.hs = 1; e.vs = 1; e.de = 0;
    repeat (3) sbq.push_back(e);
  endtask

  vec_t vt [11];

  initial begin
    bm[0][0] = 16'h07E0; bm[0][1] = 16'h1FF8; bm[0][2] = 16'h3FFC; bm[0][3] = 16'h399C;
    bm[0][4] = 16'hFFFF; bm[0][5] = 16'h0C30; bm[0][6] = 16'h1BD8; bm[0][7] = 16'hC003;
    bm[1][0] = 16'h07E0; bm[1][1] = 16'h1FF8; bm[1][2] = 16'h3FFC; bm[1][3] = 16'h399C;
    bm[1][4] = 16'hFFFF; bm[1][5] = 16'h0C30; bm[1][6] = 16'h300C; bm[1][7] = 16'h6006;

    vt[0]  = '{x: 303, y: 240, exp_rgb: BLK};
    vt[1]  = '{x: 304, y: 240, exp_rgb: GRN};
    vt[2]  = '{x: 305, y: 240, exp_rgb: GRN};
    vt[3]  = '{x: 335, y: 240, exp_rgb: GRN};
    vt[4]  = '{x: 336, y: 240, exp_rgb: BLK};
    vt[5]  = '{x: 320, y: 248, exp_rgb: BLK};
    vt[6]  = '{x: 320, y: 231, exp_rgb: BLK};
    vt[7]  = '{x: 320, y: 247, exp_rgb: BLK};
    vt[8]  = '{x: 304, y: 246, exp_rgb: GRN};
    vt[9]  = '{x: 318, y: 232, exp_rgb: GRN};
    vt[10] = '{x: 304, y: 232, exp_rgb: BLK};

    model_reset();
    #3 rst_pix_n = 1'b0;
    #1;
    check("rst_rgb", 32'(rgb), 32'(BLK));
    check("rst_pos_ready", 32'(pos_ready), 32'd1);
    do_reset();

    // Sync latency: isolated hsync, vsync and de pulses
    repeat (2) idle();
    step(700, 10, 0, 0, 1, 0, 0, 0, 0, BLK);
    idle(); idle();
    step(700, 10, 0, 1, 0, 0, 0, 0, 0, BLK);
    step(700, 10, 0, 0, 0, 0, 0, 0, 0, BLK);
    idle();
    pix(10, 10);
    idle(); idle(); idle();

    // Box edges at the reset position
    foreach (vt[i]) pixf(vt[i].x, vt[i].y, vt[i].exp_rgb);
    for (int x = 300; x < 340; x++) pix(x, 244);

    // Handshake: update offered mid-frame, committed at the boundary
    step(320, 100, 1, 1, 1, 1, 100, 50, 0, BLK);
    pixf(304, 240, GRN);
    pixf(100, 58, BLK);
    step(321, 100, 1, 1, 1, 1, 7, 7, 0, BLK);
    pixf(304, 241, GRN);
    commit_frame(0, 0, 0);
    pixf(100, 58, GRN);
    pixf(131, 58, GRN);
    pixf(304, 240, BLK);
    pixf(10, 10, BLK);
    // Transfer on the commit cycle is held for the following frame
    commit_frame(1, 200, 200);
    pixf(200, 208, BLK);
    pixf(100, 58, GRN);
    commit_frame(0, 0, 0);
    pixf(200, 208, GRN);
    pixf(100, 58, BLK);

    // Clip at the right edge, no wrap onto the next line
    step(5, 5, 1, 1, 1, 1, 630, 100, 0, BLK);
    commit_frame(0, 0, 0);
    pixf(629, 108, BLK);
    pixf(630, 108, GRN);
    pixf(639, 108, GRN);
    step(645, 108, 0, 1, 1, 0, 0, 0, 1, BLK);
    for (int x = 626; x < 662; x++) pix(x, 108);
    for (int x = 0; x < 24; x++) pixf(x, 109, BLK);

    // Asynchronous reset mid-line with a pending update
    step(5, 120, 1, 1, 1, 1, 50, 50, 0, BLK);
    for (int x = 632; x < 636; x++) step(x, 108, 1, 0, 1, 0, 0, 0, 0, BLK);
    @(negedge clk_pix);
    check("pre_rst_rgb", 32'(rgb), 32'(GRN));
    #2 rst_pix_n = 1'b0;
    #1;
    check("arst_rgb", 32'(rgb), 32'(BLK));
    check("arst_hsync_o", 32'(hsync_o), 32'd1);
    check("arst_vsync_o", 32'(vsync_o), 32'd1);
    check("arst_de_o", 32'(de_o), 32'd0);
    check("arst_pos_ready", 32'(pos_ready), 32'd1);
    check("arst_frame_start", 32'(frame_start), 32'd0);
    do_reset();
    pixf(632, 108, BLK);
    pixf(304, 240, GRN);
    commit_frame(0, 0, 0);
    pixf(50, 58, BLK);
    pixf(304, 240, GRN);

    // Animation: phase flips every 30 frame boundaries
    do_reset();
    for (int f = 0; f < 60; f++) begin
      pixf(304, 246, ((f / 30) % 2 == 1) ? BLK : GRN);
      pixf(306, 246, GRN);
      pixf(308, 246, ((f / 30) % 2 == 1) ? GRN : BLK);
      commit_frame(0, 0, 0);
    end
    pixf(304, 246, GRN);
    pixf(308, 246, BLK);

    repeat (4) idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
